// File: rtl/mem_stage_dport.sv
// MEM-stage data-memory port: issues one read/write per load/store, stalls until
// the memory responds, and returns extended load data for MEM/WB.
module mem_stage_dport #(
   parameter int WORD_LEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   input  logic                req_load,
   input  logic                req_store,
   input  logic [2:0]          req_funct3,
   input  logic [WORD_LEN-1:0] req_addr,
   input  logic [WORD_LEN-1:0] req_wdata,
   output logic                dmem_read,
   output logic                dmem_write,
   output logic [WORD_LEN-1:0] dmem_address,
   output logic [WORD_LEN-1:0] dmem_wdata,
   output logic [3:0]          dmem_wmask,
   input  logic [WORD_LEN-1:0] dmem_rdata,
   input  logic                dmem_resp,
   output logic                stall,
   output logic                resp_valid,
   output logic [WORD_LEN-1:0] load_data,
   output logic                misalign
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_q, state_d;
   logic                read_q, read_d;
   logic                write_q, write_d;
   logic [WORD_LEN-1:0] addr_q, addr_d;
   logic [WORD_LEN-1:0] wdata_q, wdata_d;
   logic [3:0]          wmask_q, wmask_d;
   logic [WORD_LEN-1:0] ldata_q, ldata_d;
   logic [2:0]          f3_q, f3_d;
   logic [1:0]          off_q, off_d;
   logic                is_load_q, is_load_d;

   logic       mem_op, illegal, misaligned, accept;
   logic       stall_c, resp_valid_c, misalign_c;
   logic [1:0] off;

   function automatic logic [WORD_LEN-1:0] fmt_load(input logic [2:0] f3,
                                                    input logic [1:0] sel,
                                                    input logic [WORD_LEN-1:0] rd);
      logic [WORD_LEN-1:0] sh;
      sh = rd >> {sel, 3'b000};
      case (f3)
         3'd0:    fmt_load = {{24{sh[7]}}, sh[7:0]};
         3'd1:    fmt_load = {{16{sh[15]}}, sh[15:0]};
         3'd2:    fmt_load = sh;
         3'd4:    fmt_load = {24'd0, sh[7:0]};
         3'd5:    fmt_load = {16'd0, sh[15:0]};
         default: fmt_load = '0;
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] sel);
      case (f3[1:0])
         2'd0:    store_mask = 4'b0001 << sel;
         2'd1:    store_mask = 4'b0011 << sel;
         default: store_mask = 4'b1111;
      endcase
   endfunction

   assign off    = req_addr[1:0];
   assign mem_op = req_valid & (req_load | req_store);

   always_comb begin
      illegal = 1'b0;
      if (req_load)
         illegal = (req_funct3 == 3'd3) | (req_funct3 == 3'd6) | (req_funct3 == 3'd7);
      else if (req_store)
         illegal = (req_funct3 >= 3'd3);
   end

   assign misaligned = ((req_funct3[1:0] == 2'd1) & off[0]) |
                       ((req_funct3[1:0] == 2'd2) & (off != 2'd0));

   always_comb begin
      state_d      = state_q;
      read_d       = read_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      ldata_d      = ldata_q;
      f3_d         = f3_q;
      off_d        = off_q;
      is_load_d    = is_load_q;
      accept       = 1'b0;
      stall_c      = 1'b0;
      resp_valid_c = 1'b0;
      misalign_c   = 1'b0;
      case (state_q)
         IDLE: begin
            misalign_c = mem_op & (illegal | misaligned);
            accept     = mem_op & ~(illegal | misaligned);
            stall_c    = accept;
            if (accept) begin
               state_d   = BUSY;
               read_d    = req_load;
               write_d   = req_store;
               addr_d    = {req_addr[WORD_LEN-1:2], 2'b00};
               wdata_d   = req_store ? (req_wdata << {off, 3'b000}) : '0;
               wmask_d   = req_store ? store_mask(req_funct3, off) : 4'b0000;
               f3_d      = req_funct3;
               off_d     = off;
               is_load_d = req_load;
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            if (dmem_resp) begin
               state_d = DONE;
               read_d  = 1'b0;
               write_d = 1'b0;
               ldata_d = is_load_q ? fmt_load(f3_q, off_q, dmem_rdata) : '0;
            end
         end
         DONE: begin
            resp_valid_c = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset clears datapath too: every output must read 0 while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= 4'b0000;
         ldata_q   <= '0;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
         is_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         read_q    <= read_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         ldata_q   <= ldata_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
         is_load_q <= is_load_d;
      end
   end

   assign dmem_read    = read_q;
   assign dmem_write   = write_q;
   assign dmem_address = addr_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_wmask   = wmask_q;
   assign load_data    = ldata_q;
   assign stall        = stall_c & rst_n;
   assign resp_valid   = resp_valid_c & rst_n;
   assign misalign     = misalign_c & rst_n;

endmodule
